// File: rtl/julia_scan_engine.sv
// julia_scan_engine
//   Escape-time Julia set generator. On start, scans an H_RES x V_RES
//   viewport in raster order, iterating z <- z^2 + c per pixel in signed
//   fixed point (WIDTH bits, FRAC fraction bits), and emits one escape-count
//   beat per pixel on a valid/ready stream.
//
// Optional feature macro: JULIA_SYMMETRY_EN
//   When defined, only the top half of the frame is iterated and every beat
//   is followed by a mirrored beat at (H_RES-1-x, V_RES-1-y) carrying the
//   same intensity (J(-z) = -J(z)). The viewport must be origin-centred.
//
// Ports
//   CLK, RESET        clock, asynchronous active-high reset
//   start, abort      frame request (IDLE only) / synchronous cancel
//   c_re, c_im        Julia constant, sampled at start
//   x_min, y_max      top-left corner of viewport, sampled at start
//   step              pixel pitch (positive), sampled at start
//   busy, done        frame in progress / one-cycle end-of-frame pulse
//   pix_valid/ready   beat handshake
//   pix_x, pix_y      beat coordinates
//   pix_addr          linear address pix_y*H_RES + pix_x
//   pix_intensity     escape count
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// INIT   | load z from the coordinate accumulators, clear counter
// ITER   | one z <- z^2 + c step per cycle, escape / cap check
// EMIT   | present beat for current pixel until accepted
// EMIT_M | present mirrored beat (JULIA_SYMMETRY_EN only)
// DONE   | one-cycle done pulse

module julia_scan_engine #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255,
  parameter int ADDR_W   = $clog2(H_RES*V_RES),
  localparam int X_W     = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int Y_W     = (V_RES > 1) ? $clog2(V_RES) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    start,
  input  logic                    abort,
  input  logic signed [WIDTH-1:0] c_re,
  input  logic signed [WIDTH-1:0] c_im,
  input  logic signed [WIDTH-1:0] x_min,
  input  logic signed [WIDTH-1:0] y_max,
  input  logic signed [WIDTH-1:0] step,
  output logic                    busy,
  output logic                    done,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [X_W-1:0]          pix_x,
  output logic [Y_W-1:0]          pix_y,
  output logic [ADDR_W-1:0]       pix_addr,
  output logic [ITER_W-1:0]       pix_intensity
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]    Y_FULL    = Y_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ITER_W-1:0] ITER_CAP  = ITER_W'(MAX_ITER);

`ifdef JULIA_SYMMETRY_EN
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES / 2 - 1);
`else
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
`endif

  // 4.0 in the widened fixed-point format
  localparam logic signed [W2-1:0] ESC_LIM = {{(W2-1){1'b0}}, 1'b1} << (FRAC + 2);

`ifdef JULIA_SYMMETRY_EN
  typedef enum logic [2:0] {IDLE, INIT, ITER, EMIT, EMIT_M, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, INIT, ITER, EMIT, DONE} state_t;
`endif

  state_t state;

  logic signed [WIDTH-1:0] c_re_q, c_im_q, x_min_q, step_q;
  logic signed [WIDTH-1:0] col_acc, row_acc;
  logic signed [WIDTH-1:0] z_re, z_im;
  logic [ITER_W-1:0]       cnt;
  logic [X_W-1:0]          cur_x;
  logic [Y_W-1:0]          cur_y;
  logic [ADDR_W-1:0]       cur_addr;

  // Operands are sign-extended to 2*WIDTH so the products keep all bits.
  logic signed [W2-1:0] z_re_x, z_im_x, c_re_x, c_im_x;
  logic signed [W2-1:0] sq_re, sq_im, sq_x;
  logic signed [W2-1:0] rr, ii, ri, mag;
  logic signed [W2-1:0] nxt_re, nxt_im;
  logic                 escape, at_cap, last_pix;

  assign z_re_x = {{WIDTH{z_re[WIDTH-1]}}, z_re};
  assign z_im_x = {{WIDTH{z_im[WIDTH-1]}}, z_im};
  assign c_re_x = {{WIDTH{c_re_q[WIDTH-1]}}, c_re_q};
  assign c_im_x = {{WIDTH{c_im_q[WIDTH-1]}}, c_im_q};

  assign sq_re  = z_re_x * z_re_x;
  assign sq_im  = z_im_x * z_im_x;
  assign sq_x   = z_re_x * z_im_x;
  assign rr     = sq_re >>> FRAC;
  assign ii     = sq_im >>> FRAC;
  assign ri     = sq_x  >>> FRAC;
  assign mag    = rr + ii;
  assign escape = mag > ESC_LIM;
  assign at_cap = cnt == ITER_CAP;

  assign nxt_re = rr - ii + c_re_x;
  assign nxt_im = (ri <<< 1) + c_im_x;

  assign last_pix = (cur_x == X_LAST) && (cur_y == Y_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pix_valid     <= 1'b0;
      pix_x         <= '0;
      pix_y         <= '0;
      pix_addr      <= '0;
      pix_intensity <= '0;
      c_re_q        <= '0;
      c_im_q        <= '0;
      x_min_q       <= '0;
      step_q        <= '0;
      col_acc       <= '0;
      row_acc       <= '0;
      z_re          <= '0;
      z_im          <= '0;
      cnt           <= '0;
      cur_x         <= '0;
      cur_y         <= '0;
      cur_addr      <= '0;
    end else if (abort && state != IDLE) begin
      // A beat offered alongside abort is dropped, not counted.
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            c_re_q   <= c_re;
            c_im_q   <= c_im;
            x_min_q  <= x_min;
            step_q   <= step;
            col_acc  <= x_min;
            row_acc  <= y_max;
            cur_x    <= '0;
            cur_y    <= '0;
            cur_addr <= '0;
            busy     <= 1'b1;
            state    <= INIT;
          end
        end

        INIT: begin
          z_re  <= col_acc;
          z_im  <= row_acc;
          cnt   <= '0;
          state <= ITER;
        end

        ITER: begin
          if (escape || at_cap) begin
            pix_intensity <= cnt;
            pix_x         <= cur_x;
            pix_y         <= cur_y;
            pix_addr      <= cur_addr;
            pix_valid     <= 1'b1;
            state         <= EMIT;
          end else begin
            z_re <= nxt_re[WIDTH-1:0];
            z_im <= nxt_im[WIDTH-1:0];
            cnt  <= cnt + ITER_W'(1);
          end
        end

        EMIT: begin
          if (pix_ready) begin
`ifdef JULIA_SYMMETRY_EN
            // Point reflection through the frame centre; the linear
            // address reflects to (H*V-1) - addr.
            pix_x    <= X_LAST - cur_x;
            pix_y    <= Y_FULL - cur_y;
            pix_addr <= ADDR_LAST - cur_addr;
            state    <= EMIT_M;
          end
        end

        EMIT_M: begin
          if (pix_ready) begin
`endif
            pix_valid <= 1'b0;
            if (last_pix) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              cur_addr <= cur_addr + ADDR_W'(1);
              if (cur_x == X_LAST) begin
                cur_x   <= '0;
                cur_y   <= cur_y + Y_W'(1);
                col_acc <= x_min_q;
                row_acc <= row_acc - step_q;
              end else begin
                cur_x   <= cur_x + X_W'(1);
                col_acc <= col_acc + step_q;
              end
              state <= INIT;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          pix_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
